// File: rtl/dwconv_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dwconv_output_buffer
// Description : Double-buffered collector for depthwise-conv results. It
//               builds a full LANES x CH result vector, one channel per beat,
//               and hands completed vectors to the pointwise stage over a
//               valid/ready handshake. While the reader holds one bank, the
//               writer fills the other one.
// Revision    : 1.0 - initial release
// ============================================================================
module dwconv_output_buffer #(
  parameter int CH     = 32,
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int POS_W  = 4,
  parameter int RELU   = 0,
  parameter int CNT_W  = $clog2(CH)
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CNT_W-1:0]              in_cnt,
  input  logic [POS_W-1:0]              in_pos,
  input  logic [LANES*DATA_W-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*CH*DATA_W-1:0]    out_data,
  output logic [POS_W-1:0]              out_pos,
  output logic                          seq_err
);

  localparam int BANK_W = LANES * CH * DATA_W;

  // Per-bank lifecycle
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]              st_q [2];
  logic [1:0]              st_d [2];
  logic [BANK_W-1:0]       bank_q [2];
  logic [POS_W-1:0]        pos_q [2];
  logic                    wr_sel_q;
  logic                    rd_sel_q;
  logic [CNT_W-1:0]        exp_cnt_q;
  logic                    seq_err_q;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_release;
  logic                    w_cnt_hit;
  logic [LANES*DATA_W-1:0] w_wdata;

  // Handshake status comes from registered bank state only
  assign in_ready  = (st_q[wr_sel_q] != ST_FULL);
  assign out_valid = (st_q[rd_sel_q] == ST_FULL);
  assign out_data  = bank_q[rd_sel_q];
  assign out_pos   = pos_q[rd_sel_q];
  assign seq_err   = seq_err_q;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (in_cnt == CNT_W'(CH - 1));
  assign w_release = out_valid && out_ready;

  // Channel index in range? (only matters when CH is not a power of two)
  always_comb begin
    w_cnt_hit = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (in_cnt == CNT_W'(c)) w_cnt_hit = 1'b1;
    end
  end

  // Optional clamp of negative lane values before they are stored
  always_comb begin
    w_wdata = in_data;
    for (int l = 0; l < LANES; l++) begin
      if ((RELU != 0) && in_data[l*DATA_W + DATA_W - 1]) begin
        w_wdata[l*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // Next state for each bank; release and fill never target the same bank
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (w_release && (rd_sel_q == 1'(b))) st_d[b] = ST_EMPTY;
      if (w_accept && (wr_sel_q == 1'(b))) st_d[b] = w_last ? ST_FULL : ST_FILLING;
    end
  end

  // Bank state, bank pointers, expected channel and sticky sequence error
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      exp_cnt_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      if (w_release) rd_sel_q <= ~rd_sel_q;
      if (w_accept) begin
        if (w_last) begin
          wr_sel_q  <= ~wr_sel_q;
          exp_cnt_q <= '0;
        end else begin
          exp_cnt_q <= in_cnt + CNT_W'(1);
        end
        if ((in_cnt != exp_cnt_q) || !w_cnt_hit) seq_err_q <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_wen;
    assign w_wen = w_accept && (wr_sel_q == 1'(b));

    // Write the accepted beat into its channel slot; other channels hold
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        bank_q[b] <= '0;
      end else if (w_wen) begin
        for (int c = 0; c < CH; c++) begin
          if (in_cnt == CNT_W'(c)) begin
            for (int l = 0; l < LANES; l++) begin
              bank_q[b][(l*CH + c)*DATA_W +: DATA_W] <= w_wdata[l*DATA_W +: DATA_W];
            end
          end
        end
      end
    end

    // Position tag of the group is the tag of its final beat
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        pos_q[b] <= '0;
      end else if (w_wen && w_last) begin
        pos_q[b] <= in_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dwconv_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwconv_output_buffer
// Description : Self-checking bench for dwconv_output_buffer (CH=4, LANES=2).
//               A RELU=0 and a RELU=1 instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwconv_output_buffer;

  localparam int CH = 4, LANES = 2, DW = 8, PW = 4, CW = 2;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic in_valid = 1'b0;
  logic [CW-1:0] in_cnt = '0;
  logic [PW-1:0] in_pos = '0;
  logic [LANES*DW-1:0] in_data = '0;
  logic out_ready = 1'b0;

  logic rdy0, ov0, se0, rdy1, ov1, se1;
  logic [63:0] od0, od1;
  logic [PW-1:0] op0, op1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dwconv_output_buffer #(.CH(CH), .LANES(LANES), .DATA_W(DW), .POS_W(PW), .RELU(0)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy0), .in_cnt(in_cnt),
    .in_pos(in_pos), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_pos(op0), .seq_err(se0));

  dwconv_output_buffer #(.CH(CH), .LANES(LANES), .DATA_W(DW), .POS_W(PW), .RELU(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy1), .in_cnt(in_cnt),
    .in_pos(in_pos), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_pos(op1), .seq_err(se1));

  typedef struct {
    logic        v;
    logic [1:0]  cnt;
    logic [3:0]  pos;
    logic [15:0] data;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic        chk_d;
    logic [63:0] e_d;
    logic [3:0]  e_pos;
  } vec_t;

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [3:0]  pos;
  } grp_t;

  vec_t tv[$];
  grp_t mq[$];
  logic [63:0] cur0, cur1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cnt = '0; in_pos = '0; in_data = '0;
    repeat (2) cycle();
    rst_b = 1'b1;
    mq.delete();
    cur0 = '0; cur1 = '0;
  endtask

  function automatic vec_t mk(logic v, logic [1:0] c, logic [3:0] p, logic [15:0] d, logic o,
                              logic er, logic eo, logic cd, logic [63:0] ed, logic [3:0] ep);
    vec_t t;
    t.v = v; t.cnt = c; t.pos = p; t.data = d; t.ordy = o;
    t.e_rdy = er; t.e_ov = eo; t.chk_d = cd; t.e_d = ed; t.e_pos = ep;
    return t;
  endfunction

  function automatic logic [7:0] relu8(logic [7:0] x);
    return x[7] ? 8'h00 : x;
  endfunction

  localparam logic [63:0] G1 = 64'h83828180_13121110;
  localparam logic [63:0] G2 = 64'hA3A2A1A0_23222120;
  localparam logic [63:0] G3 = 64'hB3B2B1B0_33323130;

  initial begin
    // ---------------- reset state ----------------
    rst_b = 1'b0;
    #12;
    chk("reset_in_ready", rdy0, 1);
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_data", od0, 0);
    chk("reset_out_pos", op0, 0);
    chk("reset_seq_err", se0, 0);
    do_reset();

    // ---------------- table: fill, hold, second fill, backpressure, drain ----------------
    for (int c = 0; c < 4; c++)
      tv.push_back(mk(1, 2'(c), (c == 3) ? 4'h5 : 4'h0, {8'h80 + 8'(c), 8'h10 + 8'(c)}, 0,
                      1, (c == 3), (c == 3), G1, 4'h5));
    for (int i = 0; i < 10; i++)
      tv.push_back(mk(0, 0, 0, 16'h0, 0, 1, 1, 1, G1, 4'h5));
    for (int c = 0; c < 4; c++)
      tv.push_back(mk(1, 2'(c), (c == 3) ? 4'h9 : 4'h0, {8'hA0 + 8'(c), 8'h20 + 8'(c)}, 0,
                      (c != 3), 1, 1, G1, 4'h5));
    tv.push_back(mk(1, 0, 0, 16'hB030, 0, 0, 1, 1, G1, 4'h5));
    tv.push_back(mk(1, 0, 0, 16'hB030, 1, 1, 1, 1, G2, 4'h9));
    for (int c = 0; c < 4; c++)
      tv.push_back(mk(1, 2'(c), (c == 3) ? 4'hC : 4'h0, {8'hB0 + 8'(c), 8'h30 + 8'(c)}, 0,
                      (c != 3), 1, 1, G2, 4'h9));
    tv.push_back(mk(0, 0, 0, 16'h0, 1, 1, 1, 1, G3, 4'hC));
    tv.push_back(mk(0, 0, 0, 16'h0, 1, 1, 0, 0, '0, 4'h0));
    tv.push_back(mk(0, 0, 0, 16'h0, 0, 1, 0, 0, '0, 4'h0));

    for (int i = 0; i < tv.size(); i++) begin
      in_valid = tv[i].v; in_cnt = tv[i].cnt; in_pos = tv[i].pos;
      in_data = tv[i].data; out_ready = tv[i].ordy;
      cycle();
      chk($sformatf("tv%0d_in_ready", i), rdy0, tv[i].e_rdy);
      chk($sformatf("tv%0d_out_valid", i), ov0, tv[i].e_ov);
      chk($sformatf("tv%0d_seq_err", i), se0, 0);
      if (tv[i].chk_d) begin
        chk($sformatf("tv%0d_out_data", i), od0, tv[i].e_d);
        chk($sformatf("tv%0d_out_pos", i), op0, tv[i].e_pos);
      end
    end

    // ---------------- back-to-back groups with reader always ready ----------------
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      logic [63:0] exp_g;
      exp_g = '0;
      for (int c = 0; c < 4; c++) begin
        in_valid = 1'b1; in_cnt = 2'(c); in_pos = 4'(g + 1);
        in_data = 16'($urandom);
        exp_g[c*8 +: 8]     = in_data[7:0];
        exp_g[(4+c)*8 +: 8] = in_data[15:8];
        cycle();
        chk($sformatf("b2b_g%0d_c%0d_in_ready", g, c), rdy0, 1);
        chk($sformatf("b2b_g%0d_c%0d_out_valid", g, c), ov0, (c == 3));
        if (c == 3) begin
          chk($sformatf("b2b_g%0d_out_pos", g), op0, 4'(g + 1));
          chk($sformatf("b2b_g%0d_out_data", g), od0, exp_g);
        end
      end
    end
    in_valid = 1'b0;
    cycle();
    chk("b2b_drained_out_valid", ov0, 0);

    // ---------------- RELU clamp ----------------
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_cnt = 2'(c); in_pos = 4'h3; in_data = 16'h07FD;
      cycle();
    end
    in_valid = 1'b0;
    chk("relu1_out_valid", ov1, 1);
    chk("relu1_out_data", od1, 64'h07070707_00000000);
    chk("relu0_out_data", od0, 64'h07070707_FDFDFDFD);

    // ---------------- sequence error, then async reset mid-group ----------------
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_cnt = 2'd0; in_data = 16'h1111; cycle();
    chk("seq_after_cnt0", se0, 0);
    in_cnt = 2'd2; cycle();
    chk("seq_after_cnt2", se0, 1);
    in_cnt = 2'd3; in_pos = 4'h6; cycle();
    chk("seq_skip_completes", ov0, 1);
    for (int c = 0; c < 4; c++) begin
      in_cnt = 2'(c); cycle();
    end
    in_valid = 1'b0; cycle();
    chk("seq_err_sticky", se0, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_cnt = 2'(c % 4); in_pos = 4'hA; in_data = 16'h5A5A; cycle();
    end
    in_valid = 1'b0;
    chk("pre_reset_out_valid", ov0, 1);
    #1 rst_b = 1'b0;
    #1;
    chk("async_rst_out_valid", ov0, 0);
    chk("async_rst_out_data", od0, 0);
    chk("async_rst_out_pos", op0, 0);
    chk("async_rst_seq_err", se0, 0);
    chk("async_rst_in_ready", rdy0, 1);
    #1 rst_b = 1'b1;

    // ---------------- randomized traffic against a group-queue model ----------------
    do_reset();
    begin
      int nxt;
      logic acc, rel;
      nxt = 0;
      for (int i = 0; i < 600; i++) begin
        in_valid  = ($urandom % 4) != 0;
        in_cnt    = 2'(nxt);
        in_data   = 16'($urandom);
        in_pos    = 4'($urandom);
        out_ready = ($urandom % 2) != 0;
        acc = in_valid && (mq.size() < 2);
        rel = (mq.size() > 0) && out_ready;
        cycle();
        if (rel) void'(mq.pop_front());
        if (acc) begin
          for (int l = 0; l < LANES; l++) begin
            cur0[(l*CH + nxt)*8 +: 8] = in_data[l*8 +: 8];
            cur1[(l*CH + nxt)*8 +: 8] = relu8(in_data[l*8 +: 8]);
          end
          if (nxt == CH - 1) begin
            grp_t g;
            g.d0 = cur0; g.d1 = cur1; g.pos = in_pos;
            mq.push_back(g);
            nxt = 0;
          end else begin
            nxt++;
          end
        end
        chk("rnd_in_ready0", rdy0, mq.size() < 2);
        chk("rnd_in_ready1", rdy1, mq.size() < 2);
        chk("rnd_out_valid0", ov0, mq.size() > 0);
        chk("rnd_out_valid1", ov1, mq.size() > 0);
        chk("rnd_seq_err", se0 | se1, 0);
        if (mq.size() > 0) begin
          chk("rnd_out_data0", od0, mq[0].d0);
          chk("rnd_out_data1", od1, mq[0].d1);
          chk("rnd_out_pos0", op0, mq[0].pos);
          chk("rnd_out_pos1", op1, mq[0].pos);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
